// File: rtl/requant_output_packer.sv
// requant_output_packer
//   Adds the output zero-point to each signed 32-bit scaled value, clamps the
//   sum to [act_min, act_max] (int8), and packs PACK consecutive bytes into a
//   32-bit word delivered over a valid/ready handshake.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready = !out_valid || out_ready)
//   in_data             signed scaled value
//   in_last             closes the current word early
//   output_offset       signed zero-point, sampled on accept
//   act_min, act_max    signed int8 clamp bounds, sampled on accept
//   out_valid/out_ready output handshake
//   out_data            packed word, lane k at [8k+7:8k], lane 0 first
//   out_keep            filled-lane mask
//   out_last            word was closed by in_last
//   sat_count           (REQ_PACK_SAT_CNT_EN only) saturating count of
//                       accepted elements that were clamped
//
// Optional feature macro: REQ_PACK_SAT_CNT_EN
module requant_output_packer #(
  parameter int unsigned PACK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [31:0] output_offset,
  input  logic [7:0]  act_min,
  input  logic [7:0]  act_max,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last
`ifdef REQ_PACK_SAT_CNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  typedef enum logic {FILLING, HOLDING} state_t;

  localparam logic [1:0] LAST_LANE = 2'(PACK - 1);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_buf;
  logic [3:0]  r_keep;

  logic signed [32:0] w_sum;
  logic signed [32:0] w_min;
  logic signed [32:0] w_max;
  logic [7:0]  w_byte;
  logic        w_sat;
  logic        w_accept;
  logic        w_close;
  logic [31:0] w_buf_next;
  logic [3:0]  w_keep_next;

  assign out_valid = (r_state == HOLDING);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_close   = (r_cnt == LAST_LANE) || in_last;

  always_comb begin
    // 33-bit sum of two sign-extended 32-bit values cannot overflow
    w_sum = {in_data[31], in_data} + {output_offset[31], output_offset};
    w_min = {{25{act_min[7]}}, act_min};
    w_max = {{25{act_max[7]}}, act_max};
    w_byte = w_sum[7:0];
    w_sat  = 1'b0;
    // Inverted bounds always resolve to act_max, ahead of the ordered clamp
    if (w_min > w_max) begin
      w_byte = act_max;
      w_sat  = 1'b1;
    end else if (w_sum < w_min) begin
      w_byte = act_min;
      w_sat  = 1'b1;
    end else if (w_sum > w_max) begin
      w_byte = act_max;
      w_sat  = 1'b1;
    end
  end

  always_comb begin
    w_buf_next  = r_buf;
    w_keep_next = r_keep;
    for (int unsigned k = 0; k < 4; k++) begin
      if (r_cnt == 2'(k)) begin
        w_buf_next[8*k +: 8] = w_byte;
        w_keep_next[k]       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= FILLING;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_keep   <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          out_data <= w_buf_next;
          out_keep <= w_keep_next;
          out_last <= in_last;
          r_state  <= HOLDING;
          r_cnt    <= '0;
          r_buf    <= '0;
          r_keep   <= '0;
        end else begin
          r_cnt  <= r_cnt + 2'd1;
          r_buf  <= w_buf_next;
          r_keep <= w_keep_next;
        end
      end
      // A drain coinciding with a new close keeps HOLDING with the new word
      if (r_state == HOLDING && out_ready && !(w_accept && w_close))
        r_state <= FILLING;
    end
  end

`ifdef REQ_PACK_SAT_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sat_count <= '0;
    else if (w_accept && w_sat && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_requant_output_packer.sv
module tb_requant_output_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] output_offset;
  logic [7:0]  act_min;
  logic [7:0]  act_max;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
`ifdef REQ_PACK_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  always #5 clk = ~clk;

  requant_output_packer #(.PACK(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .output_offset (output_offset),
    .act_min       (act_min),
    .act_max       (act_max),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last)
`ifdef REQ_PACK_SAT_CNT_EN
    ,
    .sat_count     (sat_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present one element across one rising edge; sample 1 time unit after it
  task automatic push(input logic [31:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                          input logic l);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".data"},  out_data, d);
    chk({tag, ".keep"},  {28'd0, out_keep}, {28'd0, k});
    chk({tag, ".last"},  {31'd0, out_last}, {31'd0, l});
  endtask

  initial begin
    rst           = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_last       = 1'b0;
    output_offset = '0;
    act_min       = 8'h80;
    act_max       = 8'h7F;
    out_ready     = 1'b1;
    #12;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.data",  out_data, 32'd0);
    chk("rst.keep",  {28'd0, out_keep}, 32'd0);
    chk("rst.last",  {31'd0, out_last}, 32'd0);
    chk("rst.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full word: 15, 7, clamp 210->127, clamp -290->-128
    output_offset = 32'd10;
    push(32'd5, 1'b0);
    push(-32'sd3, 1'b0);
    push(32'd200, 1'b0);
    chk("full.novalid", {31'd0, out_valid}, 32'd0);
    push(-32'sd300, 1'b0);
    chk_word("full", 32'h807F070F, 4'hF, 1'b0);
    @(posedge clk); #1;
    chk("full.onecycle", {31'd0, out_valid}, 32'd0);
`ifdef REQ_PACK_SAT_CNT_EN
    chk("sat.count", {16'd0, sat_count}, 32'd2);
`endif

    // Early close, then the next element restarts at lane 0
    output_offset = 32'd0;
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b1);
    chk_word("early", 32'h00030201, 4'h7, 1'b1);
    push(32'd9, 1'b1);
    chk_word("restart", 32'h00000009, 4'h1, 1'b1);
    @(posedge clk); #1;

    // Backpressure: first word held, in_ready low, second word intact
    out_ready = 1'b0;
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b0);
    chk("bp.ready_pre", {31'd0, in_ready}, 32'd1);
    push(32'd4, 1'b0);
    chk("bp.ready_drop", {31'd0, in_ready}, 32'd0);
    in_data  = 32'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.hold", out_data, 32'h04030201);
      chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    push(32'd5, 1'b0);
    chk("bp.drain", {31'd0, out_valid}, 32'd0);
    push(32'd6, 1'b0);
    push(32'd7, 1'b0);
    push(32'd8, 1'b0);
    chk_word("bp.second", 32'h08070605, 4'hF, 1'b0);
    @(posedge clk); #1;

    // Extremes, each as a single-lane word
    output_offset = 32'h7FFFFFFF;
    push(32'h7FFFFFFF, 1'b1);
    chk("ext.posmax", out_data, 32'h0000007F);
    output_offset = 32'hFFFFFFFF;
    push(32'h80000000, 1'b1);
    chk("ext.negmin", out_data, 32'h00000080);
    output_offset = 32'd0;
    act_min = 8'd0;
    act_max = 8'd127;
    push(-32'sd5, 1'b1);
    chk("ext.relu", out_data, 32'h00000000);
    chk("ext.relu_keep", {28'd0, out_keep}, 32'd1);
    act_min = 8'd10;
    act_max = 8'd5;
    push(32'd0, 1'b1);
    chk("ext.inverted", out_data, 32'h00000005);
    act_min = 8'h80;
    act_max = 8'h7F;
    push(32'd42, 1'b1);
    chk("ext.inrange", out_data, 32'h0000002A);
    @(posedge clk); #1;

    // Reset mid-word discards the partial word
    push(32'd11, 1'b0);
    push(32'd12, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid.valid", {31'd0, out_valid}, 32'd0);
    chk("mid.data",  out_data, 32'd0);
    chk("mid.keep",  {28'd0, out_keep}, 32'd0);
    chk("mid.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b0);
    push(32'd4, 1'b0);
    chk_word("mid.after", 32'h04030201, 4'hF, 1'b0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/requant_output_packer.md
# requant_output_packer

Downstream neighbour of `MultiplyByQuantizedMultiplier` in the requantization path. It takes each signed 32-bit scaled result, adds the output zero-point, and clamps the sum to the int8 activation range. It then packs `PACK` consecutive int8 results into one 32-bit word and hands that word to the write-back path over a valid/ready handshake.

## Interface
- `PACK`, 4: int8 lanes per output word; legal values 1..4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1  `in_data` is valid; driven from upstream `output_valid`.
- `in_ready`  out  1  block accepts an element this cycle.
- `in_data`  in  32  signed scaled value; driven from upstream `x_mul_by_quantized_multiplier`.
- `in_last`  in  1  element closes the current word early (tensor/row end).
- `output_offset`  in  32  signed output zero-point; sampled on every accept.
- `act_min`  in  8  signed lower clamp bound; sampled on every accept.
- `act_max`  in  8  signed upper clamp bound; sampled on every accept.
- `out_valid`  out  1  packed word is available.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  32  packed word; lane k occupies bits [8k+7:8k]; lane 0 is the first element.
- `out_keep`  out  4  filled-lane mask; bit k set means lane k holds data.
- `out_last`  out  1  word was closed by `in_last`.

## Operation
- An element is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational. Partial packing stalls while the output register is full and not draining.
- Arithmetic:
  - sum = sign-extended 33-bit `in_data` + `output_offset`; no wrap is possible.
  - Clamp in this order: sum < act_min gives act_min; otherwise sum > act_max gives act_max; otherwise sum[7:0].
  - If act_min > act_max, the result is act_max.
- Lane counter `cnt` runs 0..PACK-1. An accepted byte is written to lane `cnt` of the internal pack buffer, and the matching keep bit is set.
- Word close happens on accept when `cnt == PACK-1` or `in_last` is set:
  - The output register loads the buffer (including the current byte), the keep mask, and `out_last = in_last`.
  - `out_valid` is then set; `cnt`, the buffer and the keep mask clear.
  - Unfilled lanes of `out_data` are 0.
  - Bits `out_keep[3:PACK]` are always 0.
- On accept without close: `cnt` increments.
- When `out_valid && out_ready` and no new close occurs in the same cycle, `out_valid` clears. `out_data`, `out_keep` and `out_last` hold their last values.
- Simultaneous drain and close in one cycle: the output register reloads and `out_valid` stays 1. No word is dropped or duplicated.
- States: FILLING (`out_valid` = 0), HOLDING (`out_valid` = 1).

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_keep` = 0, `out_last` = 0.
  - `cnt` = 0, buffer = 0.
  - `in_ready` = 1 while `out_valid` = 0.
- Reset asserted mid-word discards the partial word and any held word immediately (asynchronous).
- Latency: `out_valid` rises on the first rising edge after the closing element is accepted, i.e. one cycle.
- Throughput: one element per cycle while `out_ready` = 1. One word per PACK cycles, or per cycle with PACK = 1.
- `out_data`, `out_keep` and `out_last` are stable while `out_valid && !out_ready`.
- The upstream stage has no backpressure. The integrating level must not drive `in_valid` while `in_ready` = 0; the block ignores `in_valid` when `in_ready` = 0.

## Configuration
- `REQ_PACK_SAT_CNT_EN` defined:
  - Adds output port `sat_count` (out, 16): the number of accepted elements whose value was clamped, on either bound.
  - The count saturates at 0xFFFF and resets to 0.
  - It updates on the same edge as the accept.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Full word: offset = 10, min = -128, max = 127, PACK = 4, inputs 5, -3, 200, -300 with `out_ready` = 1. Required: one cycle later `out_data` = 0x807F070F, `out_keep` = 0xF, `out_last` = 0, `out_valid` one cycle wide.
- Early close: offset = 0, inputs 1, 2, 3 with `in_last` on the third. Required: `out_data` = 0x00030201, `out_keep` = 0x7, `out_last` = 1. A following element then starts at lane 0.
- Backpressure: `out_ready` = 0, stream 8 elements. Required: `in_ready` drops on the cycle after the first word closes and the word holds stable. After `out_ready` = 1 the stream resumes, the second word arrives intact, and no element is lost.
- Extremes: `in_data` = 0x7FFFFFFF with offset 0x7FFFFFFF gives 0x7F. `in_data` = 0x80000000 with offset -1 gives 0x80. ReLU case min = 0, max = 127: -5 gives 0x00. Inverted bounds min = 10, max = 5: 0 gives 0x05.
- Reset mid-word: accept 2 elements, pulse `rst` low. Required: all outputs 0 and `in_ready` = 1. The next 4 elements 1..4 (offset 0) give 0x04030201.
- With `REQ_PACK_SAT_CNT_EN`, reuse the full-word vector. Required: `sat_count` = 2.
